ring_seq_arb: RTL

RING_SEQ_ARB -- requirements
Module: ring_seq_arb

---
 rtl/ring_sched_pkg.sv | 19 +
 rtl/johnson_core.sv | 47 ++++
 rtl/ring_seq_arb.sv | 116 +++++++++++
 3 files changed

// File: rtl/ring_sched_pkg.sv
// Shared types and constants for the Johnson-ring sequenced arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ring_sched_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 4;

    // Every ring bit takes this value while the ring is idle.
    localparam logic RING_IDLE_BIT = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/johnson_core.sv
// Johnson ring counter with clear, enable and illegal-code recovery.
// Latency: ring updates one cycle after en/clr; wrap is combinational from ring.
// Backpressure: none; en simply freezes the ring.
//
// Ports:
//   clk, rst   - clock, synchronous active-low reset
//   en         - advance the ring one step this cycle
//   clr        - force the ring to idle on the next edge (beats en)
//   ring       - current Johnson code
//   wrap       - ring is in the last code of a rotation while enabled
module johnson_core
    import ring_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] ring,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] RING_IDLE = {WIDTH{RING_IDLE_BIT}};
    localparam logic [WIDTH-1:0] WRAP_CODE = {1'b1, {(WIDTH-1){1'b0}}};

    // A legal code is a block of ones anchored at the LSB (0..011..1)
    // or at the MSB (1..100..0); everything else is corruption.
    function automatic logic is_legal(input logic [WIDTH-1:0] r);
        logic [WIDTH-1:0] inv;
        inv = ~r;
        return ((r & (r + 1'b1)) == '0) || ((inv & (inv + 1'b1)) == '0);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            ring <= RING_IDLE;
        end else if (clr || !is_legal(ring)) begin
            ring <= RING_IDLE;
        end else if (en) begin
            ring <= {ring[WIDTH-2:0], ~ring[WIDTH-1]};
        end
    end

    assign wrap = en && (ring == WRAP_CODE);

endmodule

// File: rtl/ring_seq_arb.sv
// Two-requester round-robin arbiter that runs each job for len Johnson rotations.
// Latency: gnt one cycle after req seen in IDLE; job = 1 + 2*WIDTH*len + 1 cycles.
// Backpressure: none; req is a level and stays pending until granted, abort cancels.
//
// Ports:
//   clk, rst     - clock, synchronous active-low reset
//   req[1:0]     - job request per requester (level)
//   len0, len1   - rotation count per requester, sampled in GRANT
//   abort        - cancel current job, back to IDLE without done
//   gnt[1:0]     - one-hot grant pulse
//   done[1:0]    - one-hot completion pulse
//   busy         - FSM not in IDLE
//   owner        - current / most recent owner index
//   ring, wrap   - Johnson ring state and end-of-rotation flag
module ring_seq_arb
    import ring_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [CNT_W-1:0] len0,
    input  logic [CNT_W-1:0] len1,
    input  logic             abort,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic             owner,
    output logic [WIDTH-1:0] ring,
    output logic             wrap
);

    state_t           state;
    state_t           state_nxt;
    logic             last_owner;
    logic [CNT_W-1:0] rot_cnt;
    logic             winner;
    logic [CNT_W-1:0] len_sel;
    logic             ring_en;
    logic             ring_clr;
    logic             last_rot;

    // Single requester wins outright; on contention the one that did not
    // own the ring last time goes first.
    always_comb begin
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_owner;
            default: winner = 1'b0;
        endcase
    end

    assign len_sel  = owner ? len1 : len0;
    assign last_rot = (rot_cnt <= CNT_W'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req != 2'b00) state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                if (abort)                 state_nxt = ST_IDLE;
                else if (len_sel == '0)    state_nxt = ST_DONE;
                else                       state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (abort)                 state_nxt = ST_IDLE;
                else if (wrap && last_rot) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            rot_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && req != 2'b00) owner <= winner;
            if (state == ST_GRANT) rot_cnt <= len_sel;
            if (state == ST_RUN && wrap && !abort) rot_cnt <= rot_cnt - 1'b1;
            // Both a completed and an aborted job count as that owner's turn.
            if (state != ST_IDLE && (abort || state == ST_DONE)) last_owner <= owner;
        end
    end

    // The ring only moves in RUN; an abort clears it on the same edge the
    // FSM drops to IDLE.
    assign ring_en  = (state == ST_RUN);
    assign ring_clr = (state != ST_RUN) || abort;

    johnson_core #(.WIDTH(WIDTH)) u_core (
        .clk  (clk),
        .rst  (rst),
        .en   (ring_en),
        .clr  (ring_clr),
        .ring (ring),
        .wrap (wrap)
    );

    assign busy = (state != ST_IDLE);
    assign gnt  = (state == ST_GRANT)           ? (2'b01 << owner) : 2'b00;
    assign done = (state == ST_DONE && !abort)  ? (2'b01 << owner) : 2'b00;

endmodule
